// File: rtl/init_pulse_terminal_pkg.sv
// ----------------------------------------------------------------------------
// init_pulse_terminal_pkg
// Shared types and helpers for the init pulse terminal and related strobe
// primitives.
//   state_e   : FSM state encoding (2 bits)
//   act_lvl   : active output level for a given ACTIVE_HIGH setting
//   idle_lvl  : idle output level for a given ACTIVE_HIGH setting
// ----------------------------------------------------------------------------
package init_pulse_terminal_pkg;

    typedef enum logic [1:0] {
        ST_START   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PULSE   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_e;

    function automatic logic act_lvl(input int active_high);
        return (active_high != 0);
    endfunction

    function automatic logic idle_lvl(input int active_high);
        return (active_high == 0);
    endfunction

endpackage

// File: rtl/init_pulse_terminal_if.sv
// ----------------------------------------------------------------------------
// init_pulse_terminal_if
// Control/status bundle of an init pulse terminal.
//   enable  : gates trigger acceptance           (master -> slave)
//   trigger : rising edge requests a pulse       (master -> slave)
//   z       : registered terminal output         (slave -> master)
//   busy    : high while pulsing or in holdoff   (slave -> master)
//   done    : one-cycle strobe when z goes idle  (slave -> master)
// ----------------------------------------------------------------------------
interface init_pulse_terminal_if;
    logic enable;
    logic trigger;
    logic z;
    logic busy;
    logic done;

    modport master (
        output enable,
        output trigger,
        input  z,
        input  busy,
        input  done
    );

    modport slave (
        input  enable,
        input  trigger,
        output z,
        output busy,
        output done
    );
endinterface

// File: rtl/init_pulse_terminal_sync_rise_detect.sv
// ----------------------------------------------------------------------------
// sync_rise_detect
// Rising-edge detector for a signal already synchronous to clock.
//   clock  : clock
//   reset  : synchronous active-high reset, clears the history register
//   d_i    : input signal
//   rise_o : d_i & ~(d_i delayed one clock), combinational
// ----------------------------------------------------------------------------
module sync_rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/init_pulse_terminal.sv
// ----------------------------------------------------------------------------
// init_pulse_terminal
// Tie-off style terminal that drives a PULSE_LEN-clock active pulse after
// reset release (POST_RESET) and on accepted trigger rising edges, then
// settles to the idle level. Optional holdoff ignores triggers after a pulse.
//   clock : clock
//   reset : synchronous active-high reset (aborts any pulse, no done)
//   term  : slave modport - enable/trigger in, z/busy/done out
//
// state   | meaning
// --------+-------------------------------------------------------------
// START   | left reset with POST_RESET=1, fires on the next clock
// IDLE    | z idle, waiting for enabled trigger edge
// PULSE   | z active, cnt counts remaining active clocks
// HOLDOFF | z idle, triggers ignored until cnt expires
// ----------------------------------------------------------------------------
module init_pulse_terminal
    import init_pulse_terminal_pkg::*;
#(
    parameter int PULSE_LEN   = 16,
    parameter int HOLDOFF_LEN = 0,
    parameter int CNT_W       = 16,
    parameter int ACTIVE_HIGH = 1,
    parameter int POST_RESET  = 1,
    parameter int RETRIG_EN   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    init_pulse_terminal_if.slave  term
);

    localparam logic ACT_LVL  = act_lvl(ACTIVE_HIGH);
    localparam logic IDLE_LVL = idle_lvl(ACTIVE_HIGH);

    localparam logic [CNT_W-1:0] PULSE_RLD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] HOLD_RLD  =
        (HOLDOFF_LEN > 0) ? CNT_W'(HOLDOFF_LEN - 1) : '0;

    if (PULSE_LEN < 1 || PULSE_LEN > (2 ** CNT_W) - 1) begin : g_bad_pulse_len
        $error("init_pulse_terminal: PULSE_LEN out of range for CNT_W");
    end
    if (HOLDOFF_LEN < 0 || HOLDOFF_LEN > (2 ** CNT_W) - 1) begin : g_bad_holdoff_len
        $error("init_pulse_terminal: HOLDOFF_LEN out of range for CNT_W");
    end

    logic trig_rise;

    sync_rise_detect u_rise (
        .clock  (clock),
        .reset  (reset),
        .d_i    (term.trigger),
        .rise_o (trig_rise)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               z_q, z_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_START: begin
                state_d = ST_PULSE;
                cnt_d   = PULSE_RLD;
            end
            ST_IDLE: begin
                if (trig_rise && term.enable) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_RLD;
                end
            end
            ST_PULSE: begin
                // A retrigger takes priority over the terminal count, so an
                // edge on the last active clock extends without a done.
                if ((RETRIG_EN != 0) && trig_rise) begin
                    cnt_d = PULSE_RLD;
                end else if (cnt_q == '0) begin
                    done_d = 1'b1;
                    if (HOLDOFF_LEN > 0) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = HOLD_RLD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so z changes on the
        // same edge that accepts the trigger.
        z_d    = (state_d == ST_PULSE) ? ACT_LVL : IDLE_LVL;
        busy_d = (state_d == ST_PULSE) || (state_d == ST_HOLDOFF);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= (POST_RESET != 0) ? ST_START : ST_IDLE;
            cnt_q   <= '0;
            z_q     <= IDLE_LVL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign term.z    = z_q;
    assign term.busy = busy_q;
    assign term.done = done_q;

endmodule

// File: tb/tb_init_pulse_terminal.sv
// ----------------------------------------------------------------------------
// tb_init_pulse_terminal
// Three differently configured terminals share reset/enable/trigger. A
// remaining-cycles model per instance predicts z/busy/done every cycle.
//   A: PULSE_LEN=4 HOLDOFF=0 ACTIVE_HIGH=1 POST_RESET=1 RETRIG=1
//   B: PULSE_LEN=3 HOLDOFF=3 ACTIVE_HIGH=0 POST_RESET=0 RETRIG=0
//   C: PULSE_LEN=1 HOLDOFF=2 ACTIVE_HIGH=1 POST_RESET=1 RETRIG=1 CNT_W=3
// ----------------------------------------------------------------------------
module tb_init_pulse_terminal;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic trigger = 1'b0;

    always #5 clock = ~clock;

    init_pulse_terminal_if if_a();
    init_pulse_terminal_if if_b();
    init_pulse_terminal_if if_c();

    assign if_a.enable = enable;  assign if_a.trigger = trigger;
    assign if_b.enable = enable;  assign if_b.trigger = trigger;
    assign if_c.enable = enable;  assign if_c.trigger = trigger;

    init_pulse_terminal #(.PULSE_LEN(4), .HOLDOFF_LEN(0), .CNT_W(16),
        .ACTIVE_HIGH(1), .POST_RESET(1), .RETRIG_EN(1))
        u_a (.clock(clock), .reset(reset), .term(if_a));
    init_pulse_terminal #(.PULSE_LEN(3), .HOLDOFF_LEN(3), .CNT_W(8),
        .ACTIVE_HIGH(0), .POST_RESET(0), .RETRIG_EN(0))
        u_b (.clock(clock), .reset(reset), .term(if_b));
    init_pulse_terminal #(.PULSE_LEN(1), .HOLDOFF_LEN(2), .CNT_W(3),
        .ACTIVE_HIGH(1), .POST_RESET(1), .RETRIG_EN(1))
        u_c (.clock(clock), .reset(reset), .term(if_c));

    logic [2:0] dut_z, dut_busy, dut_done;
    assign dut_z    = {if_c.z,    if_b.z,    if_a.z};
    assign dut_busy = {if_c.busy, if_b.busy, if_a.busy};
    assign dut_done = {if_c.done, if_b.done, if_a.done};

    function automatic int cfg_pl(input int i);
        case (i) 0: return 4; 1: return 3; default: return 1; endcase
    endfunction
    function automatic int cfg_hl(input int i);
        case (i) 0: return 0; 1: return 3; default: return 2; endcase
    endfunction
    function automatic bit cfg_ah(input int i);
        return (i != 1);
    endfunction
    function automatic bit cfg_pr(input int i);
        return (i != 1);
    endfunction
    function automatic bit cfg_rt(input int i);
        return (i != 1);
    endfunction

    // Model: rem = active clocks still to show (including current),
    // hold = holdoff clocks still to run, start = fire on next clock.
    int rem   [3];
    int hold  [3];
    bit prev  [3];
    bit start [3];
    bit m_done[3];
    bit m_valid = 1'b0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit r, input bit en, input bit t);
        bit e;
        if (r) begin
            rem[i] = 0; hold[i] = 0; prev[i] = 1'b0;
            start[i] = cfg_pr(i); m_done[i] = 1'b0;
        end else begin
            e = t && !prev[i];
            prev[i] = t;
            m_done[i] = 1'b0;
            if (start[i]) begin
                start[i] = 1'b0;
                rem[i] = cfg_pl(i);
            end else if (rem[i] > 0) begin
                if (e && cfg_rt(i)) begin
                    rem[i] = cfg_pl(i);
                end else begin
                    rem[i] = rem[i] - 1;
                    if (rem[i] == 0) begin
                        m_done[i] = 1'b1;
                        hold[i] = cfg_hl(i);
                    end
                end
            end else if (hold[i] > 0) begin
                hold[i] = hold[i] - 1;
            end else if (e && en) begin
                rem[i] = cfg_pl(i);
            end
        end
    endtask

    function automatic bit exp_z(input int i);
        return (rem[i] > 0) ? cfg_ah(i) : !cfg_ah(i);
    endfunction
    function automatic bit exp_busy(input int i);
        return (rem[i] > 0) || (hold[i] > 0);
    endfunction

    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) model_step(i, reset, enable, trigger);
        if (reset) m_valid = 1'b1;
    end

    always @(negedge clock) begin
        if (m_valid) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_z[%0d]", i),    dut_z[i],    exp_z(i));
                chk($sformatf("model_busy[%0d]", i), dut_busy[i], exp_busy(i));
                chk($sformatf("model_done[%0d]", i), dut_done[i], m_done[i]);
            end
        end
    end

    task automatic cyc(input bit r, input bit e, input bit t);
        @(negedge clock);
        reset = r; enable = e; trigger = t;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit r, e, t;

        repeat (3) cyc(1, 0, 0);
        chk("rst_a_z", if_a.z, 1'b0);
        chk("rst_a_busy", if_a.busy, 1'b0);
        chk("rst_a_done", if_a.done, 1'b0);
        chk("rst_b_z", if_b.z, 1'b1);
        chk("rst_b_busy", if_b.busy, 1'b0);

        // post-reset pulse: A active on release edges 1..4, done at 5
        cyc(0, 0, 0);
        chk("pr_a_z1", if_a.z, 1'b1);
        chk("pr_a_busy1", if_a.busy, 1'b1);
        chk("pr_c_z1", if_c.z, 1'b1);
        chk("pr_b_idle", if_b.z, 1'b1);
        cyc(0, 0, 0);
        chk("pr_c_done", if_c.done, 1'b1);
        chk("pr_c_hold", if_c.busy, 1'b1);
        chk("pr_a_z2", if_a.z, 1'b1);
        cyc(0, 0, 0);
        chk("pr_a_z3", if_a.z, 1'b1);
        cyc(0, 0, 0);
        chk("pr_a_z4", if_a.z, 1'b1);
        chk("pr_a_nodone4", if_a.done, 1'b0);
        cyc(0, 0, 0);
        chk("pr_a_z5", if_a.z, 1'b0);
        chk("pr_a_done5", if_a.done, 1'b1);
        chk("pr_a_busy5", if_a.busy, 1'b0);
        cyc(0, 0, 0);
        chk("pr_a_done6", if_a.done, 1'b0);

        // edge with enable low is dropped; held-high trigger gives nothing
        cyc(0, 0, 1);
        chk("en0_a_z", if_a.z, 1'b0);
        chk("en0_b_z", if_b.z, 1'b1);
        cyc(0, 1, 1);
        chk("held_a_z", if_a.z, 1'b0);
        chk("held_b_busy", if_b.busy, 1'b0);
        cyc(0, 1, 0);

        // F: A fires and retriggers at F+2; B (no retrig) fires once
        cyc(0, 1, 1);
        chk("f0_a_z", if_a.z, 1'b1);
        chk("f0_b_z", if_b.z, 1'b0);
        cyc(0, 1, 0);
        chk("f1_a_z", if_a.z, 1'b1);
        cyc(0, 1, 1);
        chk("f2_a_z", if_a.z, 1'b1);
        chk("f2_b_z", if_b.z, 1'b0);
        cyc(0, 1, 1);
        chk("f3_a_z", if_a.z, 1'b1);
        chk("f3_b_z", if_b.z, 1'b1);
        chk("f3_b_done", if_b.done, 1'b1);
        chk("f3_b_busy", if_b.busy, 1'b1);
        cyc(0, 1, 1);
        chk("f4_a_z", if_a.z, 1'b1);
        cyc(0, 1, 1);
        chk("f5_a_z", if_a.z, 1'b1);
        chk("f5_b_busy", if_b.busy, 1'b1);
        cyc(0, 1, 1);
        chk("f6_a_z", if_a.z, 1'b0);
        chk("f6_a_done", if_a.done, 1'b1);
        chk("f6_b_busy", if_b.busy, 1'b0);

        // reset mid-pulse aborts without done, then a full post-reset pulse
        cyc(0, 1, 0);
        cyc(0, 1, 1);
        chk("g0_a_z", if_a.z, 1'b1);
        cyc(0, 1, 1);
        cyc(1, 1, 1);
        chk("g2_a_z", if_a.z, 1'b0);
        chk("g2_a_busy", if_a.busy, 1'b0);
        chk("g2_a_done", if_a.done, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 1);
            chk($sformatf("g_rel_a_z%0d", k), if_a.z, 1'b1);
        end
        cyc(0, 1, 1);
        chk("g_rel_a_done", if_a.done, 1'b1);

        // randomized phase, checked every cycle against the model
        r = 1'b0; e = 1'b1; t = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) e = ~e;
            if ($urandom_range(0, 2) == 0) t = ~t;
            cyc(r, e, t);
        end
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        @(negedge clock);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
